pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction fetch stage: owns the program counter, issues reads to the synchronous instruction memory and presents instruction plus PC to decode.
- inst_pc_out feeds the branch target adder's pc_in.
- The resolved branch target and taken flag come back into this block to redirect the PC.
- Provides stall hold (1-entry skid), branch squash and host enable.

Parameters:
- INST_ADDR_WIDTH, 9, PC and instruction address width.
- INST_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  host run enable; low blocks new fetch issue.
- stall_in  in  1  decode cannot accept; hold outputs.
- branch_taken  in  1  one-cycle redirect strobe.
- branch_target  in  INST_ADDR_WIDTH  redirect PC.
- imem_addr  out  INST_ADDR_WIDTH  instruction memory read address.
- imem_rd_en  out  1  read strobe; data returns the next cycle.
- imem_rdata  in  INST_WIDTH  read data, valid the cycle after imem_rd_en.
- inst_out  out  INST_WIDTH  fetched instruction.
- inst_pc_out  out  INST_ADDR_WIDTH  PC of inst_out.
- inst_valid  out  1  inst_out and inst_pc_out are meaningful.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pc=RESET_PC, f_valid=0, f_pc=0, skid_valid=0, skid data=0, inst_valid=0, inst_out=0, inst_pc_out=0.
  - Reset mid-operation discards all in-flight and held state immediately.
- Combinational memory interface:
  - imem_addr=pc.
  - issue=en & ~stall_in & ~branch_taken.
  - imem_rd_en=issue.
- Issue (at the edge):
  - If issue: pc<=pc+1, wrapping modulo 2^INST_ADDR_WIDTH (0x1FF -> 0x000). Also f_valid<=1, f_pc<=pc.
  - Else: f_valid<=0.
- Return: when f_valid=1, imem_rdata holds the word for f_pc.
- Output stage when stall_in=0:
  - If skid_valid: output <= skid, skid_valid<=0. Issue gating guarantees f_valid=0 in this case.
  - Else if f_valid: output <= {imem_rdata, f_pc}, inst_valid<=1.
  - Else: inst_valid<=0; inst_out and inst_pc_out hold their values.
- Output stage when stall_in=1:
  - Outputs hold.
  - If f_valid: skid <= {imem_rdata, f_pc}, skid_valid<=1.
  - Issue gating bounds in-flight reads to one, so the skid never overflows. The skid being full while f_valid=1 is an assertion failure.
- Latency: read issued in cycle N gives inst_valid high in cycle N+2 (no stall).
- branch_taken=1 in cycle B (overrides stall_in and en):
  - At the edge: pc<=branch_target, f_valid<=0, skid_valid<=0, inst_valid<=0.
  - Cycle B+1 issues branch_target; inst_valid returns high in cycle B+3 with inst_pc_out=branch_target.
  - Penalty: 2 bubbles.
- en low:
  - No issue; pc holds.
  - An in-flight read still completes into the output or skid.
  - Re-raising en resumes at the held pc.
- Simultaneous stall_in and branch_taken: branch wins and the squash is applied. Outputs go invalid even while stalled.

Decomposition:
- Shared package (arya_core_pkg): INST_ADDR_WIDTH, INST_WIDTH, RESET_PC defaults, and an instruction/PC bundle typedef reused by decode and the branch target adder.
- One sub-module, fetch_skid_buffer: 1-entry holding register with valid bit and load/unload/flush controls. The PC and issue logic stays in the top.

Test Plan:
- Reset with en=1, memory word[i]=0xA000_0000+i, no stalls -> inst_valid from cycle 3 after reset release; inst_pc_out = 0,1,2,... with inst_out = 0xA000_0000, 0xA000_0001, ... one per cycle.
- stall_in high for 3 cycles starting when inst_pc_out=5 -> outputs hold PC 5 and its word. On release: PC 6 (from skid), then PC 7, with no gap or duplicate.
- branch_taken with branch_target=0x040 while PC 10 is on the output -> inst_valid=0 for 2 cycles, then inst_pc_out=0x040, 0x041, ...; PCs 11 and 12 never appear.
- pc reaches 0x1FF -> next inst_pc_out=0x000 and fetch continues.
- branch_taken coincident with stall_in and a full skid -> all squashed; next valid instruction is branch_target.
- Assert rst_n low mid-stream with the skid full -> inst_valid=0 and pc=RESET_PC immediately (asynchronous); after release the fetch sequence restarts at RESET_PC.

Source files
------------

// File: rtl/arya_core_pkg.sv
// Shared core definitions: fetch widths, reset PC and the instruction/PC bundle
// handed from fetch to decode and the branch target adder.
package arya_core_pkg;

  localparam int unsigned DEF_INST_ADDR_WIDTH = 9;
  localparam int unsigned DEF_INST_WIDTH      = 32;
  localparam int unsigned DEF_RESET_PC        = 0;

  typedef struct packed {
    logic [DEF_INST_WIDTH-1:0]      inst;
    logic [DEF_INST_ADDR_WIDTH-1:0] pc;
  } inst_bundle_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction and its PC.
// Flush beats load, and load beats unload.
module fetch_skid_buffer
  import arya_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_INST_WIDTH,
  parameter int unsigned PC_WIDTH   = DEF_INST_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  unload,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] load_inst,
  input  logic [PC_WIDTH-1:0]   load_pc,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues synchronous imem reads and presents
// instruction plus PC to decode, with stall skid, branch squash and run enable.
module pc_fetch_unit
  import arya_core_pkg::*;
#(
  parameter int unsigned                INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH,
  parameter int unsigned                INST_WIDTH      = DEF_INST_WIDTH,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = INST_ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       stall_in,
  input  logic                       branch_taken,
  input  logic [INST_ADDR_WIDTH-1:0] branch_target,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  output logic                       imem_rd_en,
  input  logic [INST_WIDTH-1:0]      imem_rdata,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [INST_ADDR_WIDTH-1:0] inst_pc_out,
  output logic                       inst_valid
);

  logic                       issue;
  logic [INST_ADDR_WIDTH-1:0] pc;
  logic                       f_valid;
  logic [INST_ADDR_WIDTH-1:0] f_pc;
  logic                       skid_load;
  logic                       skid_unload;
  logic                       skid_valid;
  logic [INST_WIDTH-1:0]      skid_inst;
  logic [INST_ADDR_WIDTH-1:0] skid_pc;

  // Never issuing under stall keeps at most one read in flight, so the skid cannot overflow.
  assign issue      = en & ~stall_in & ~branch_taken;
  assign imem_addr  = pc;
  assign imem_rd_en = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      f_valid <= 1'b0;
      f_pc    <= '0;
    end else begin
      f_valid <= issue;
      if (branch_taken) begin
        pc <= branch_target;
      end else if (issue) begin
        pc   <= pc + 1'b1;
        f_pc <= pc;
      end
    end
  end

  assign skid_load   = stall_in & f_valid & ~branch_taken;
  assign skid_unload = ~stall_in & skid_valid & ~branch_taken;

  fetch_skid_buffer #(
    .DATA_WIDTH(INST_WIDTH),
    .PC_WIDTH  (INST_ADDR_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .unload   (skid_unload),
    .flush    (branch_taken),
    .load_inst(imem_rdata),
    .load_pc  (f_pc),
    .valid    (skid_valid),
    .inst     (skid_inst),
    .pc       (skid_pc)
  );

  // Branch squashes the output even while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid  <= 1'b0;
      inst_out    <= '0;
      inst_pc_out <= '0;
    end else if (branch_taken) begin
      inst_valid <= 1'b0;
    end else if (!stall_in) begin
      if (skid_valid) begin
        inst_valid  <= 1'b1;
        inst_out    <= skid_inst;
        inst_pc_out <= skid_pc;
      end else if (f_valid) begin
        inst_valid  <= 1'b1;
        inst_out    <= imem_rdata;
        inst_pc_out <= f_pc;
      end else begin
        inst_valid <= 1'b0;
      end
    end
  end

  skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(skid_valid && f_valid));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, corner sequences and a randomized run
// checked against a transaction-level model (queue of issued PCs).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        stall_in = 1'b0;
  logic        branch_taken = 1'b0;
  logic [8:0]  branch_target = '0;
  logic [8:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst_out;
  logic [8:0]  inst_pc_out;
  logic        inst_valid;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .stall_in     (stall_in),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rd_en   (imem_rd_en),
    .imem_rdata   (imem_rdata),
    .inst_out     (inst_out),
    .inst_pc_out  (inst_pc_out),
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word[i] = 0xA000_0000 + i.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 32'hA000_0000 + 32'(imem_addr);
  end

  // Reference model: PCs issued but not yet presented, in order.
  logic [8:0]  m_pc;
  logic [8:0]  m_q[$];
  logic        m_valid;
  logic [8:0]  m_opc;
  logic [31:0] m_oinst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 9'h000;
    m_q.delete();
    m_valid = 1'b0;
    m_opc = '0;
    m_oinst = '0;
  endtask

  task automatic model_step(input logic e, input logic s, input logic b, input logic [8:0] t);
    if (b) begin
      m_pc = t;
      m_q.delete();
      m_valid = 1'b0;
    end else begin
      if (!s) begin
        if (m_q.size() > 0) begin
          m_opc = m_q.pop_front();
          m_oinst = 32'hA000_0000 + 32'(m_opc);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (e && !s) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 9'd1;
      end
    end
  endtask

  // Drive one cycle's inputs, then sample at the falling edge against the model.
  task automatic cyc(input logic e, input logic s, input logic b, input logic [8:0] t);
    en = e;
    stall_in = s;
    branch_taken = b;
    branch_target = t;
    @(negedge clk);
    chk("model_valid", 32'(inst_valid), 32'(m_valid));
    chk("model_pc", 32'(inst_pc_out), 32'(m_opc));
    chk("model_inst", inst_out, m_oinst);
    chk("model_rd_en", 32'(imem_rd_en), 32'(e & ~s & ~b));
    chk("model_addr", 32'(imem_addr), 32'(m_pc));
  endtask

  task automatic adv();
    model_step(en, stall_in, branch_taken, branch_target);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic e, input logic s, input logic b, input logic [8:0] t);
    cyc(e, s, b, t);
    adv();
  endtask

  task automatic expect_out(input string name, input logic v, input logic [8:0] p);
    chk({name, "_valid"}, 32'(inst_valid), 32'(v));
    if (v) begin
      chk({name, "_pc"}, 32'(inst_pc_out), 32'(p));
      chk({name, "_inst"}, inst_out, 32'hA000_0000 + 32'(p));
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    stall_in = 1'b0;
    branch_taken = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h000);
    chk("rst_pc_out", 32'(inst_pc_out), 32'h000);
    chk("rst_inst", inst_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic       stall;
    logic       br;
    logic [8:0] tgt;
    logic       exp_valid;
    logic [8:0] exp_pc;
  } vec_t;

  vec_t tbl[21];

  task automatic row(input int k, input logic s, input logic b, input logic [8:0] t,
                     input logic v, input logic [8:0] p);
    tbl[k] = '{en: 1'b1, stall: s, br: b, tgt: t, exp_valid: v, exp_pc: p};
  endtask

  initial begin
    // Stream from reset, 3-cycle stall at PC 5, branch to 0x040 while PC 10 is shown.
    row(0, 0, 0, 0, 0, 0);      row(1, 0, 0, 0, 0, 0);      row(2, 0, 0, 0, 1, 9'd0);
    row(3, 0, 0, 0, 1, 9'd1);   row(4, 0, 0, 0, 1, 9'd2);   row(5, 0, 0, 0, 1, 9'd3);
    row(6, 0, 0, 0, 1, 9'd4);   row(7, 1, 0, 0, 1, 9'd5);   row(8, 1, 0, 0, 1, 9'd5);
    row(9, 1, 0, 0, 1, 9'd5);   row(10, 0, 0, 0, 1, 9'd5);  row(11, 0, 0, 0, 1, 9'd6);
    row(12, 0, 0, 0, 1, 9'd7);  row(13, 0, 0, 0, 1, 9'd8);  row(14, 0, 0, 0, 1, 9'd9);
    row(15, 0, 1, 9'h040, 1, 9'd10);
    row(16, 0, 0, 0, 0, 0);     row(17, 0, 0, 0, 0, 0);     row(18, 0, 0, 0, 1, 9'h040);
    row(19, 0, 0, 0, 1, 9'h041); row(20, 0, 0, 0, 1, 9'h042);

    do_reset();
    for (int k = 0; k < 21; k++) begin
      cyc(tbl[k].en, tbl[k].stall, tbl[k].br, tbl[k].tgt);
      expect_out($sformatf("tbl%0d", k), tbl[k].exp_valid, tbl[k].exp_pc);
      adv();
    end

    // PC wrap 0x1FF -> 0x000.
    run(1, 0, 1, 9'h1FE);
    run(1, 0, 0, 0);
    run(1, 0, 0, 0);
    cyc(1, 0, 0, 0); expect_out("wrap0", 1, 9'h1FE); adv();
    cyc(1, 0, 0, 0); expect_out("wrap1", 1, 9'h1FF); adv();
    cyc(1, 0, 0, 0); expect_out("wrap2", 1, 9'h000); adv();
    cyc(1, 0, 0, 0); expect_out("wrap3", 1, 9'h001); adv();

    // Branch while stalled with the skid full.
    run(1, 1, 0, 0);
    cyc(1, 1, 0, 0); expect_out("skidfull", 1, 9'h002); adv();
    run(1, 1, 1, 9'h123);
    cyc(1, 0, 0, 0); expect_out("sqz0", 0, 0); adv();
    cyc(1, 0, 0, 0); expect_out("sqz1", 0, 0); adv();
    cyc(1, 0, 0, 0); expect_out("sqz2", 1, 9'h123); adv();
    cyc(1, 0, 0, 0); expect_out("sqz3", 1, 9'h124); adv();

    // Asynchronous reset mid-stream with the skid full.
    run(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    do_reset();
    cyc(1, 0, 0, 0); expect_out("rr0", 0, 0); adv();
    cyc(1, 0, 0, 0); expect_out("rr1", 0, 0); adv();
    cyc(1, 0, 0, 0); expect_out("rr2", 1, 9'h000); adv();
    cyc(1, 0, 0, 0); expect_out("rr3", 1, 9'h001); adv();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic       e, s, b;
      logic [8:0] t;
      e = ($urandom_range(0, 99) < 85);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 8);
      t = ($urandom_range(0, 3) == 0) ? 9'(9'h1F8 + 9'($urandom_range(0, 7)))
                                      : 9'($urandom_range(0, 511));
      run(e, s, b, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
